// File: rtl/pkmn_party_sprite_sel_pkg.sv
// -----------------------------------------------------------------------------
// pkmn_pkg : shared types for the party sprite selector.
//   cmd_op_e   - command opcode (add / switch / evolve / reserved)
//   line_e     - species line (GRASS, FIRE, WATER)
//   slot_t     - one party slot {line, stage, occupied}
//   INVALID_ID - all-ones sprite ID, truncated to the ID width by users
// -----------------------------------------------------------------------------
package pkmn_pkg;

  typedef enum logic [1:0] {
    OP_ADD    = 2'b00,
    OP_SWITCH = 2'b01,
    OP_EVOLVE = 2'b10,
    OP_RSVD   = 2'b11
  } cmd_op_e;

  typedef enum logic [1:0] {
    GRASS = 2'd0,
    FIRE  = 2'd1,
    WATER = 2'd2
  } line_e;

  // Wide enough for up to eight evolution stages.
  localparam int STAGE_W = 3;

  typedef struct packed {
    line_e              line;
    logic [STAGE_W-1:0] stage;
    logic               occupied;
  } slot_t;

  localparam logic [31:0] INVALID_ID = 32'hFFFF_FFFF;

  localparam slot_t EMPTY_SLOT = '{line: GRASS, stage: {STAGE_W{1'b0}}, occupied: 1'b0};

endpackage

// File: rtl/pkmn_party_sprite_sel_if.sv
// -----------------------------------------------------------------------------
// pkmn_party_sprite_sel_if : command handshake bundle.
//   cmd_valid  - command strobe            (master -> slave)
//   cmd_op     - opcode                    (master -> slave)
//   cmd_arg    - species line / slot index (master -> slave)
//   cmd_ready  - slave can accept          (slave -> master)
//   cmd_err    - one-cycle reject pulse    (slave -> master)
// -----------------------------------------------------------------------------
interface pkmn_party_sprite_sel_if #(
  parameter int ARG_W = 2
);
  import pkmn_pkg::*;

  logic             cmd_valid;
  cmd_op_e          cmd_op;
  logic [ARG_W-1:0] cmd_arg;
  logic             cmd_ready;
  logic             cmd_err;

  modport master (
    output cmd_valid, cmd_op, cmd_arg,
    input  cmd_ready, cmd_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_arg,
    output cmd_ready, cmd_err
  );

endinterface

// File: rtl/pkmn_party_sprite_sel_id_calc.sv
// -----------------------------------------------------------------------------
// pkmn_sprite_id_calc : combinational slot -> back-sprite ID.
//   slot - {line, stage, occupied}
//   id   - BACK_BASE + stage*NUM_LINES + line, or all-ones when the slot is
//          empty or the sum does not fit in ID_W bits.
// -----------------------------------------------------------------------------
module pkmn_sprite_id_calc
  import pkmn_pkg::*;
#(
  parameter int BACK_BASE = 3,
  parameter int NUM_LINES = 3,
  parameter int ID_W      = 5
) (
  input  slot_t           slot,
  output logic [ID_W-1:0] id
);

  localparam logic [31:0] MAX_ID = 32'((64'd1 << ID_W) - 64'd1);

  logic [31:0] raw;

  // Sum at 32 bits so overflow of the ID width can be detected.
  always_comb begin
    raw = 32'(BACK_BASE) + 32'(slot.stage) * 32'(NUM_LINES) + 32'(slot.line);
    if (!slot.occupied || (raw > MAX_ID)) begin
      id = ID_W'(INVALID_ID);
    end else begin
      id = ID_W'(raw);
    end
  end

endmodule

// File: rtl/pkmn_party_sprite_sel.sv
// -----------------------------------------------------------------------------
// pkmn_party_sprite_sel : party-aware back-sprite selector.
//   Clk, Reset   - clock, async active-high reset
//   cmd          - command handshake (slave modport)
//   pkmnID       - registered back-sprite ID of the active member
//   id_valid     - active slot occupied
//   active_slot  - active party index
//   party_count  - number of occupied slots
//   busy         - evolution animation in progress
// Build option: define PKMN_EVO_ANIM_EN for the evolution flash animation;
// without it evolve completes in one cycle and busy is tied low.
// -----------------------------------------------------------------------------
module pkmn_party_sprite_sel
  import pkmn_pkg::*;
#(
  parameter int NUM_SLOTS    = 3,
  parameter int NUM_LINES    = 3,
  parameter int NUM_STAGES   = 3,
  parameter int ID_W         = 5,
  parameter int BACK_BASE    = 3,
  parameter int FLASH_PERIOD = 8,
  parameter int FLASH_COUNT  = 6,
  localparam int SLOT_W      = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1,
  localparam int CNT_W       = $clog2(NUM_SLOTS + 1)
) (
  input  logic                     Clk,
  input  logic                     Reset,
  pkmn_party_sprite_sel_if.slave   cmd,
  output logic [ID_W-1:0]          pkmnID,
  output logic                     id_valid,
  output logic [SLOT_W-1:0]        active_slot,
  output logic [CNT_W-1:0]         party_count,
  output logic                     busy
);

  slot_t             slots_r   [NUM_SLOTS];
  slot_t             slots_nxt [NUM_SLOTS];
  logic [SLOT_W-1:0] active_r, active_nxt;
  logic [CNT_W-1:0]  count_r, count_nxt;
  logic [ID_W-1:0]   id_r;
  logic              valid_r, ready_r, err_r, busy_r;
  logic              accept, reject, start_evo, finish_evo;
  slot_t             cur_slot, evo_slot, view_slot;
  logic [ID_W-1:0]   view_id, evo_id;

`ifdef PKMN_EVO_ANIM_EN
  localparam int PER_W = (FLASH_PERIOD > 1) ? $clog2(FLASH_PERIOD) : 1;
  localparam int TOG_W = $clog2(FLASH_COUNT + 1);

  typedef enum logic {ST_IDLE = 1'b0, ST_EVOLVE = 1'b1} state_e;

  state_e           state_r;
  logic [PER_W-1:0] per_cnt_r;
  logic [TOG_W-1:0] tog_cnt_r;
  logic             show_new_r;
  logic             per_last;

  assign per_last = (per_cnt_r == PER_W'(FLASH_PERIOD - 1));
`endif

  // Decode the command and build the party state for the next cycle.
  always_comb begin
    slots_nxt  = slots_r;
    active_nxt = active_r;
    count_nxt  = count_r;
    accept     = cmd.cmd_valid & ready_r;
    reject     = 1'b0;
    start_evo  = 1'b0;
    finish_evo = 1'b0;
    cur_slot   = slots_r[active_r];
    evo_slot   = cur_slot;
    evo_slot.stage = cur_slot.stage + STAGE_W'(1);
    if (accept) begin
      case (cmd.cmd_op)
        OP_ADD: begin
          if ((32'(count_r) >= 32'(NUM_SLOTS)) || (32'(cmd.cmd_arg) >= 32'(NUM_LINES))) begin
            reject = 1'b1;
          end else begin
            slots_nxt[SLOT_W'(count_r)] = '{line: line_e'(2'(cmd.cmd_arg)),
                                            stage: {STAGE_W{1'b0}}, occupied: 1'b1};
            if (count_r == {CNT_W{1'b0}}) begin
              active_nxt = {SLOT_W{1'b0}};
            end else begin
              active_nxt = active_r;
            end
            count_nxt = count_r + CNT_W'(1);
          end
        end
        OP_SWITCH: begin
          if (32'(cmd.cmd_arg) >= 32'(count_r)) begin
            reject = 1'b1;
          end else begin
            active_nxt = SLOT_W'(cmd.cmd_arg);
          end
        end
        OP_EVOLVE: begin
          if ((count_r == {CNT_W{1'b0}}) || (32'(cur_slot.stage) >= 32'(NUM_STAGES - 1))) begin
            reject = 1'b1;
          end else begin
`ifdef PKMN_EVO_ANIM_EN
            start_evo = 1'b1;
`else
            slots_nxt[active_r] = evo_slot;
`endif
          end
        end
        default: reject = 1'b1;
      endcase
    end else begin
      reject = 1'b0;
    end
`ifdef PKMN_EVO_ANIM_EN
    // The stage commits only when the animation completes.
    if ((state_r == ST_EVOLVE) && per_last && (tog_cnt_r == TOG_W'(FLASH_COUNT - 1))) begin
      finish_evo = 1'b1;
      slots_nxt[active_r] = evo_slot;
    end else begin
      finish_evo = 1'b0;
    end
`endif
    view_slot = slots_nxt[active_nxt];
  end

  // view_id reflects the post-edge party; evo_id is the active slot one stage up.
  pkmn_sprite_id_calc #(.BACK_BASE(BACK_BASE), .NUM_LINES(NUM_LINES), .ID_W(ID_W)) u_view_id (
    .slot (view_slot),
    .id   (view_id)
  );

  pkmn_sprite_id_calc #(.BACK_BASE(BACK_BASE), .NUM_LINES(NUM_LINES), .ID_W(ID_W)) u_evo_id (
    .slot (evo_slot),
    .id   (evo_id)
  );

  // Party registers, output registers and the evolution FSM.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slots_r[i] <= EMPTY_SLOT;
      end
      active_r <= {SLOT_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      id_r     <= ID_W'(INVALID_ID);
      valid_r  <= 1'b0;
      ready_r  <= 1'b1;
      err_r    <= 1'b0;
      busy_r   <= 1'b0;
`ifdef PKMN_EVO_ANIM_EN
      state_r    <= ST_IDLE;
      per_cnt_r  <= {PER_W{1'b0}};
      tog_cnt_r  <= {TOG_W{1'b0}};
      show_new_r <= 1'b0;
`endif
    end else begin
      slots_r  <= slots_nxt;
      active_r <= active_nxt;
      count_r  <= count_nxt;
      valid_r  <= view_slot.occupied;
      err_r    <= reject;
`ifdef PKMN_EVO_ANIM_EN
      case (state_r)
        ST_IDLE: begin
          if (start_evo) begin
            state_r    <= ST_EVOLVE;
            ready_r    <= 1'b0;
            busy_r     <= 1'b1;
            per_cnt_r  <= {PER_W{1'b0}};
            tog_cnt_r  <= {TOG_W{1'b0}};
            show_new_r <= 1'b1;
            id_r       <= evo_id;
          end else begin
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
            id_r    <= view_id;
          end
        end
        ST_EVOLVE: begin
          if (finish_evo) begin
            state_r    <= ST_IDLE;
            ready_r    <= 1'b1;
            busy_r     <= 1'b0;
            per_cnt_r  <= {PER_W{1'b0}};
            tog_cnt_r  <= {TOG_W{1'b0}};
            show_new_r <= 1'b0;
            id_r       <= view_id;
          end else if (per_last) begin
            // While evolving, view_id is still the old-stage sprite.
            per_cnt_r  <= {PER_W{1'b0}};
            tog_cnt_r  <= tog_cnt_r + TOG_W'(1);
            show_new_r <= ~show_new_r;
            id_r       <= show_new_r ? view_id : evo_id;
          end else begin
            per_cnt_r <= per_cnt_r + PER_W'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          ready_r <= 1'b1;
          busy_r  <= 1'b0;
          id_r    <= view_id;
        end
      endcase
`else
      ready_r <= 1'b1;
      busy_r  <= 1'b0;
      id_r    <= view_id;
`endif
    end
  end

  assign cmd.cmd_ready = ready_r;
  assign cmd.cmd_err   = err_r;
  assign pkmnID        = id_r;
  assign id_valid      = valid_r;
  assign active_slot   = active_r;
  assign party_count   = count_r;
  assign busy          = busy_r;

endmodule

// File: tb/tb_pkmn_party_sprite_sel.sv
// -----------------------------------------------------------------------------
// tb_pkmn_party_sprite_sel : self-checking bench for pkmn_party_sprite_sel.
// Directed scenarios plus randomized commands against a party model.
// Honours PKMN_EVO_ANIM_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_pkmn_party_sprite_sel;
  import pkmn_pkg::*;

  localparam int FLASH_PERIOD = 8;
  localparam int FLASH_COUNT  = 6;

  logic       Clk;
  logic       Reset;
  logic [4:0] pkmnID;
  logic       id_valid;
  logic [1:0] active_slot;
  logic [1:0] party_count;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  pkmn_party_sprite_sel_if #(.ARG_W(2)) cmd_if ();

  pkmn_party_sprite_sel #(
    .NUM_SLOTS(3), .NUM_LINES(3), .NUM_STAGES(3), .ID_W(5), .BACK_BASE(3),
    .FLASH_PERIOD(FLASH_PERIOD), .FLASH_COUNT(FLASH_COUNT)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .cmd         (cmd_if.slave),
    .pkmnID      (pkmnID),
    .id_valid    (id_valid),
    .active_slot (active_slot),
    .party_count (party_count),
    .busy        (busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // ---------------- reference model ----------------
  int m_line [3];
  int m_stage[3];
  int m_count;
  int m_active;

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      m_line[i]  = 0;
      m_stage[i] = 0;
    end
    m_count  = 0;
    m_active = 0;
  endfunction

  function automatic int exp_id();
    int v;
    if (m_count == 0) return 31;
    v = 3 + m_stage[m_active] * 3 + m_line[m_active];
    return (v > 31) ? 31 : v;
  endfunction

  // {pkmnID, id_valid, active_slot, party_count, cmd_ready, busy} when idle
  function automatic logic [11:0] exp_vec();
    return {5'(exp_id()), (m_count > 0), 2'(m_active), 2'(m_count), 1'b1, 1'b0};
  endfunction

  function automatic logic [11:0] obs_vec();
    return {pkmnID, id_valid, active_slot, party_count, cmd_if.cmd_ready, busy};
  endfunction

  function automatic void model_cmd(input int op, input int arg, output bit rej, output bit evo);
    rej = 1'b0;
    evo = 1'b0;
    case (op)
      0: if (m_count == 3 || arg >= 3) rej = 1'b1;
         else begin
           m_line[m_count]  = arg;
           m_stage[m_count] = 0;
           if (m_count == 0) m_active = 0;
           m_count++;
         end
      1: if (arg >= m_count) rej = 1'b1; else m_active = arg;
      2: if (m_count == 0 || m_stage[m_active] == 2) rej = 1'b1;
         else begin
           m_stage[m_active]++;
           evo = 1'b1;
         end
      default: rej = 1'b1;
    endcase
  endfunction

  // ---------------- drivers ----------------
  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1;
    cmd_if.cmd_valid = 1'b0;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    model_reset();
    @(negedge Clk);
  endtask

  // Presents one command for exactly one edge; returns at the negedge after it.
  task automatic send(input int op, input int arg);
    @(negedge Clk);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = cmd_op_e'(2'(op));
    cmd_if.cmd_arg   = 2'(arg);
    @(posedge Clk);
    #1;
    cmd_if.cmd_valid = 1'b0;
    @(negedge Clk);
  endtask

  // Follows the flash animation until busy drops (bounded).
  task automatic watch_evolve(input int new_id, input int old_id,
                              output int busy_len, output int bad);
    int e;
    busy_len = 0;
    bad      = 0;
    while (busy === 1'b1 && busy_len < 200) begin
      e = (((busy_len / FLASH_PERIOD) % 2) == 0) ? new_id : old_id;
      if (pkmnID !== 5'(e) || cmd_if.cmd_ready !== 1'b0) bad++;
      busy_len++;
      @(negedge Clk);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(negedge Clk);
    Reset = 1'b1;
    cmd_if.cmd_valid = 1'b0;
    #1;
    checks++;
    if (obs_vec() !== 12'b11111_0_00_00_1_0 || cmd_if.cmd_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_values got=%b err=%b exp=%b err=0", obs_vec(), cmd_if.cmd_err, 12'b11111_0_00_00_1_0);
    end
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    model_reset();
    @(negedge Clk);
  endtask

  task automatic test_add_switch();
    bit rej, evo;
    send(0, 1); model_cmd(0, 1, rej, evo);
    checks++;
    if (pkmnID !== 5'b00100 || obs_vec() !== exp_vec() || cmd_if.cmd_err !== 1'b0) begin
      failures++;
      $display("FAIL add_fire got=%b exp=%b", obs_vec(), exp_vec());
    end
    send(0, 0); model_cmd(0, 0, rej, evo);
    send(0, 2); model_cmd(0, 2, rej, evo);
    checks++;
    if (party_count !== 2'd3 || obs_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL add_three got=%b exp=%b", obs_vec(), exp_vec());
    end
    send(0, 0); model_cmd(0, 0, rej, evo);
    checks++;
    if (cmd_if.cmd_err !== 1'b1 || party_count !== 2'd3 || obs_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL add_full err=%b got=%b exp=%b", cmd_if.cmd_err, obs_vec(), exp_vec());
    end
    @(negedge Clk);
    checks++;
    if (cmd_if.cmd_err !== 1'b0) begin
      failures++;
      $display("FAIL err_one_cycle got=%b exp=0", cmd_if.cmd_err);
    end
    send(1, 2); model_cmd(1, 2, rej, evo);
    checks++;
    if (pkmnID !== 5'b00101 || obs_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL switch_2 got=%b exp=%b", obs_vec(), exp_vec());
    end
    send(1, 3); model_cmd(1, 3, rej, evo);
    checks++;
    if (cmd_if.cmd_err !== 1'b1 || pkmnID !== 5'b00101 || obs_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL switch_3 err=%b got=%b exp=%b", cmd_if.cmd_err, obs_vec(), exp_vec());
    end
  endtask

  // Active slot is 2 (water, stage 0) on entry.
  task automatic test_evolve();
    bit rej, evo;
    int len, bad;
    send(2, 0); model_cmd(2, 0, rej, evo);
`ifdef PKMN_EVO_ANIM_EN
    watch_evolve(8, 5, len, bad);
    checks++;
    if (len !== 48 || bad !== 0) begin
      failures++;
      $display("FAIL evolve_flash busy_len=%0d bad=%0d exp busy_len=48 bad=0", len, bad);
    end
`endif
    checks++;
    if (pkmnID !== 5'b01000 || obs_vec() !== exp_vec() || cmd_if.cmd_err !== 1'b0) begin
      failures++;
      $display("FAIL evolve_1 got=%b exp=%b", obs_vec(), exp_vec());
    end
    send(2, 0); model_cmd(2, 0, rej, evo);
`ifdef PKMN_EVO_ANIM_EN
    watch_evolve(11, 8, len, bad);
    checks++;
    if (len !== 48 || bad !== 0) begin
      failures++;
      $display("FAIL evolve2_flash busy_len=%0d bad=%0d exp busy_len=48 bad=0", len, bad);
    end
`endif
    checks++;
    if (pkmnID !== 5'b01011 || obs_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL evolve_2 got=%b exp=%b", obs_vec(), exp_vec());
    end
    send(2, 0); model_cmd(2, 0, rej, evo);
    checks++;
    if (cmd_if.cmd_err !== 1'b1 || busy !== 1'b0 || pkmnID !== 5'b01011) begin
      failures++;
      $display("FAIL evolve_max err=%b busy=%b id=%b exp err=1 busy=0 id=01011", cmd_if.cmd_err, busy, pkmnID);
    end
  endtask

  task automatic test_busy_and_reset();
    bit rej, evo;
    int errs;
    do_reset();
    send(0, 2); model_cmd(0, 2, rej, evo);
    send(2, 0);
`ifdef PKMN_EVO_ANIM_EN
    errs = 0;
    for (int i = 0; i < 20; i++) begin
      if (cmd_if.cmd_err !== 1'b0 || busy !== 1'b1 || party_count !== 2'd1) errs++;
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_op    = cmd_op_e'(2'($urandom_range(0, 3)));
      cmd_if.cmd_arg   = 2'($urandom_range(0, 3));
      @(negedge Clk);
    end
    cmd_if.cmd_valid = 1'b0;
    checks++;
    if (errs !== 0) begin
      failures++;
      $display("FAIL busy_ignore bad_cycles=%0d exp=0", errs);
    end
`else
    errs = 0;
    checks++;
    if (pkmnID !== 5'b01000 || busy !== 1'b0) begin
      failures++;
      $display("FAIL evolve_1cycle id=%b busy=%b exp id=01000 busy=0", pkmnID, busy);
    end
`endif
    Reset = 1'b1;
    #1;
    checks++;
    if (obs_vec() !== 12'b11111_0_00_00_1_0 || cmd_if.cmd_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_evolve got=%b exp=%b", obs_vec(), 12'b11111_0_00_00_1_0);
    end
    @(negedge Clk);
    Reset = 1'b0;
    model_reset();
    // The re-added member must start at stage 0 again.
    send(0, 2); model_cmd(0, 2, rej, evo);
    checks++;
    if (pkmnID !== 5'b00101 || obs_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL readd_after_reset got=%b exp=%b", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_rejects();
    bit rej, evo;
    do_reset();
    send(2, 0); model_cmd(2, 0, rej, evo);
    checks++;
    if (cmd_if.cmd_err !== 1'b1 || pkmnID !== 5'b11111 || id_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL empty_evolve err=%b id=%b valid=%b exp err=1 id=11111 valid=0", cmd_if.cmd_err, pkmnID, id_valid);
    end
    send(0, 3); model_cmd(0, 3, rej, evo);
    checks++;
    if (cmd_if.cmd_err !== 1'b1 || obs_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL add_bad_line err=%b got=%b exp=%b", cmd_if.cmd_err, obs_vec(), exp_vec());
    end
    send(3, 1); model_cmd(3, 1, rej, evo);
    checks++;
    if (cmd_if.cmd_err !== 1'b1 || obs_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL reserved_op err=%b got=%b exp=%b", cmd_if.cmd_err, obs_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    bit rej, evo;
    int op, arg, old_id, len, bad;
    do_reset();
    for (int n = 0; n < 120; n++) begin
      op  = $urandom_range(0, 3);
      arg = $urandom_range(0, 3);
      old_id = exp_id();
      send(op, arg);
      model_cmd(op, arg, rej, evo);
`ifdef PKMN_EVO_ANIM_EN
      if (evo) begin
        watch_evolve(exp_id(), old_id, len, bad);
        checks++;
        if (len !== FLASH_PERIOD * FLASH_COUNT || bad !== 0) begin
          failures++;
          $display("FAIL rand_flash n=%0d busy_len=%0d bad=%0d exp busy_len=%0d bad=0", n, len, bad, FLASH_PERIOD * FLASH_COUNT);
        end
      end
`endif
      checks++;
      if (cmd_if.cmd_err !== rej || (evo == 1'b0 && obs_vec() !== exp_vec())) begin
        failures++;
        $display("FAIL rand_cmd n=%0d op=%0d arg=%0d err=%b exp_err=%b got=%b exp=%b", n, op, arg, cmd_if.cmd_err, rej, obs_vec(), exp_vec());
      end
      if (evo) begin
        checks++;
        if (obs_vec() !== exp_vec()) begin
          failures++;
          $display("FAIL rand_evolve n=%0d got=%b exp=%b", n, obs_vec(), exp_vec());
        end
      end
      if (($urandom % 16) == 0) begin
        do_reset();
      end
    end
  endtask

  initial begin
    Reset            = 1'b1;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = OP_ADD;
    cmd_if.cmd_arg   = 2'd0;
    model_reset();
    test_reset();
    test_add_switch();
    test_evolve();
    test_busy_and_reset();
    test_rejects();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
